// File: rtl/alu_unit_if.sv
// Bus between the control unit and the ALU. The control side drives the request.
// The ALU side returns the registered result, the status flags and the accumulator write strobe.
interface alu_unit_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic       acc_write;
  logic       busy;
  logic       carry;
  logic       zero;

  modport master (
    output start, op, a, b,
    input  result, acc_write, busy, carry, zero
  );

  modport slave (
    input  start, op, a, b,
    output result, acc_write, busy, carry, zero
  );
endinterface

// File: rtl/alu_unit.sv
// Sequential 8-bit ALU feeding the accumulator. Logic, add/sub and shift ops take one cycle.
// Multiply is an 8-iteration shift-add with a busy handshake.
module alu_unit (
  input  logic     clk,
  input  logic     rst,
  alu_unit_if.slave bus
);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_e      state_q,     state_d;
  logic [7:0]  result_q,    result_d;
  logic        carry_q,     carry_d;
  logic        zero_q,      zero_d;
  logic        acc_write_q, acc_write_d;
  logic [15:0] mcand_q,     mcand_d;
  logic [7:0]  mplier_q,    mplier_d;
  logic [15:0] product_q,   product_d;
  logic [2:0]  count_q,     count_d;

  logic [8:0]  alu_res;     // {carry, result} for single-cycle ops
  logic [15:0] prod_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_res = '0;
    unique case (bus.op)
      OP_ADD: alu_res = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB: alu_res = {1'b0, bus.a} - {1'b0, bus.b};  // bit 8 is the borrow
      OP_AND: alu_res = {1'b0, bus.a & bus.b};
      OP_OR:  alu_res = {1'b0, bus.a | bus.b};
      OP_XOR: alu_res = {1'b0, bus.a ^ bus.b};
      OP_SHL: alu_res = {bus.a[7], bus.a[6:0], 1'b0};
      OP_SHR: alu_res = {bus.a[0], 1'b0, bus.a[7:1]};
      OP_MUL: alu_res = '0;
    endcase
  end

  assign prod_next = product_q + (mplier_q[0] ? mcand_q : 16'h0000);

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    acc_write_d = 1'b0;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    product_d   = product_q;
    count_d     = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            mcand_d   = {8'h00, bus.a};
            mplier_d  = bus.b;
            product_d = '0;
            count_d   = '0;
            state_d   = S_MUL;
          end else begin
            result_d    = alu_res[7:0];
            carry_d     = alu_res[8];
            zero_d      = (alu_res[7:0] == 8'h00);
            acc_write_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        product_d = prod_next;
        mcand_d   = {mcand_q[14:0], 1'b0};
        mplier_d  = {1'b0, mplier_q[7:1]};
        count_d   = count_q + 3'd1;
        // The eighth iteration publishes straight from the adder output.
        if (count_q == 3'd7) begin
          result_d    = prod_next[7:0];
          carry_d     = |prod_next[15:8];
          zero_d      = (prod_next[7:0] == 8'h00);
          acc_write_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the multiplier working registers are reset too, so an aborted multiply leaves no residue.
      state_q     <= S_IDLE;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      acc_write_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      product_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      acc_write_q <= acc_write_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      product_q   <= product_d;
      count_q     <= count_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.acc_write = acc_write_q;
  assign bus.busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus a randomized run.
// The randomized run is compared against an arithmetic reference model.
module tb_alu_unit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   aw_cnt    = 0;

  alu_unit_if bus ();

  alu_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Counts acc_write pulses, one sample per cycle at the edge that closes it.
  always @(posedge clk) if (bus.acc_write === 1'b1) aw_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {carry, result}, computed with plain integer arithmetic.
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    c  = 1'b0;
    case (op)
      OP_ADD:  begin r = ia + ib; c = (r > 255); end
      OP_SUB:  begin r = ia - ib + 256; c = (ia < ib); end
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      OP_XOR:  r = int'(a ^ b);
      OP_SHL:  begin r = ia * 2; c = (ia >= 128); end
      OP_SHR:  begin r = ia / 2; c = (ia % 2 == 1); end
      default: begin r = ia * ib; c = (r > 255); end
    endcase
    return {c, 8'(r % 256)};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  task automatic test_reset();
    int aw0;
    aw0 = aw_cnt;
    rst = 1'b1;
    drive(OP_ADD, 8'h11, 8'h22);
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.result !== 8'h00) $display("FAIL reset result: got %h want 00", bus.result); else pass_cnt++;
    total_cnt++; if (bus.carry !== 1'b0) $display("FAIL reset carry: got %b want 0", bus.carry); else pass_cnt++;
    total_cnt++; if (bus.zero !== 1'b0) $display("FAIL reset zero: got %b want 0", bus.zero); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", bus.busy); else pass_cnt++;
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    total_cnt++; if (aw_cnt !== aw0) $display("FAIL reset acc_write pulses: got %0d want 0", aw_cnt - aw0); else pass_cnt++;
  endtask

  task automatic test_add_sub();
    logic [2:0] t_op [3];
    logic [7:0] t_a [3], t_b [3], t_r [3];
    logic       t_c [3], t_z [3];
    t_op = '{OP_ADD, OP_SUB, OP_SUB};
    t_a  = '{8'hF0, 8'h05, 8'h03};
    t_b  = '{8'h20, 8'h05, 8'h05};
    t_r  = '{8'h10, 8'h00, 8'hFE};
    t_c  = '{1'b1, 1'b0, 1'b1};
    t_z  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(t_op[i], t_a[i], t_b[i]);
      @(negedge clk);
      bus.start = 1'b0;
      total_cnt++; if (bus.acc_write !== 1'b1) $display("FAIL addsub[%0d] acc_write cycle1: got %b want 1", i, bus.acc_write); else pass_cnt++;
      total_cnt++; if (bus.result !== t_r[i]) $display("FAIL addsub[%0d] result: got %h want %h", i, bus.result, t_r[i]); else pass_cnt++;
      total_cnt++; if (bus.carry !== t_c[i]) $display("FAIL addsub[%0d] carry: got %b want %b", i, bus.carry, t_c[i]); else pass_cnt++;
      total_cnt++; if (bus.zero !== t_z[i]) $display("FAIL addsub[%0d] zero: got %b want %b", i, bus.zero, t_z[i]); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.acc_write !== 1'b0) $display("FAIL addsub[%0d] acc_write cycle2: got %b want 0", i, bus.acc_write); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] t_op [5];
    logic [7:0] t_a [5], t_b [5], t_r [5];
    logic       t_c [5];
    int aw0;
    t_op = '{OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
    t_a  = '{8'hCC, 8'hCC, 8'hCC, 8'h81, 8'h81};
    t_b  = '{8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00};
    t_r  = '{8'h88, 8'hEE, 8'h66, 8'h02, 8'h40};
    t_c  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    aw0 = aw_cnt;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) begin
        total_cnt++; if (bus.acc_write !== 1'b1) $display("FAIL b2b[%0d] acc_write: got %b want 1", k - 1, bus.acc_write); else pass_cnt++;
        total_cnt++; if (bus.result !== t_r[k-1]) $display("FAIL b2b[%0d] result: got %h want %h", k - 1, bus.result, t_r[k-1]); else pass_cnt++;
        total_cnt++; if (bus.carry !== t_c[k-1]) $display("FAIL b2b[%0d] carry: got %b want %b", k - 1, bus.carry, t_c[k-1]); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL b2b[%0d] busy: got %b want 0", k - 1, bus.busy); else pass_cnt++;
      end
      if (k < 5) drive(t_op[k], t_a[k], t_b[k]);
      else bus.start = 1'b0;
      @(negedge clk);
    end
    total_cnt++; if (bus.acc_write !== 1'b0) $display("FAIL b2b trailing acc_write: got %b want 0", bus.acc_write); else pass_cnt++;
    total_cnt++; if (aw_cnt - aw0 !== 5) $display("FAIL b2b pulse count: got %0d want 5", aw_cnt - aw0); else pass_cnt++;
  endtask

  task automatic test_mul();
    logic [7:0] t_a [2], t_b [2], t_r [2];
    logic       t_c [2], t_z [2];
    t_a = '{8'h0C, 8'h20};
    t_b = '{8'h0B, 8'h10};
    t_r = '{8'h84, 8'h00};
    t_c = '{1'b0, 1'b1};
    t_z = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(OP_MUL, t_a[i], t_b[i]);
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (c == 1) bus.start = 1'b0;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mul[%0d] busy cycle%0d: got %b want 1", i, c, bus.busy); else pass_cnt++;
        total_cnt++; if (bus.acc_write !== 1'b0) $display("FAIL mul[%0d] acc_write cycle%0d: got %b want 0", i, c, bus.acc_write); else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL mul[%0d] busy cycle9: got %b want 0", i, bus.busy); else pass_cnt++;
      total_cnt++; if (bus.acc_write !== 1'b1) $display("FAIL mul[%0d] acc_write cycle9: got %b want 1", i, bus.acc_write); else pass_cnt++;
      total_cnt++; if (bus.result !== t_r[i]) $display("FAIL mul[%0d] result: got %h want %h", i, bus.result, t_r[i]); else pass_cnt++;
      total_cnt++; if (bus.carry !== t_c[i]) $display("FAIL mul[%0d] carry: got %b want %b", i, bus.carry, t_c[i]); else pass_cnt++;
      total_cnt++; if (bus.zero !== t_z[i]) $display("FAIL mul[%0d] zero: got %b want %b", i, bus.zero, t_z[i]); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.acc_write !== 1'b0) $display("FAIL mul[%0d] acc_write cycle10: got %b want 0", i, bus.acc_write); else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    int aw0;
    @(negedge clk);
    aw0 = aw_cnt;
    drive(OP_MUL, 8'h03, 8'h07);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 4) drive(OP_ADD, 8'hFF, 8'hFF);
      if (c == 5) begin
        bus.start = 1'b0;
        bus.a = 8'h5A;
        bus.b = 8'hA5;
      end
      if (c == 9) begin
        total_cnt++; if (bus.result !== 8'h15) $display("FAIL busy result cycle9: got %h want 15", bus.result); else pass_cnt++;
        total_cnt++; if (bus.acc_write !== 1'b1) $display("FAIL busy acc_write cycle9: got %b want 1", bus.acc_write); else pass_cnt++;
      end
    end
    total_cnt++; if (aw_cnt - aw0 !== 1) $display("FAIL busy pulse count: got %0d want 1", aw_cnt - aw0); else pass_cnt++;
    total_cnt++; if (bus.result !== 8'h15) $display("FAIL busy result held: got %h want 15", bus.result); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    int aw0;
    @(negedge clk);
    aw0 = aw_cnt;
    drive(OP_MUL, 8'hFF, 8'hFF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rstmul busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if ({bus.result, bus.carry, bus.zero} !== 10'h000) $display("FAIL rstmul flags: got %h/%b/%b want 00/0/0", bus.result, bus.carry, bus.zero); else pass_cnt++;
    repeat (8) @(negedge clk);
    total_cnt++; if (aw_cnt !== aw0) $display("FAIL rstmul pulses: got %0d want 0", aw_cnt - aw0); else pass_cnt++;
    drive(OP_MUL, 8'h02, 8'h03);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    total_cnt++; if (bus.acc_write !== 1'b1 || bus.result !== 8'h06) $display("FAIL rstmul fresh mul: got aw=%b res=%h want aw=1 res=06", bus.acc_write, bus.result); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] a, b;
    logic [8:0] exp;
    logic       early;
    int         lat;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      op  = 3'($urandom_range(0, 7));
      a   = 8'($urandom);
      b   = 8'($urandom);
      exp = model(op, a, b);
      lat = (op == OP_MUL) ? 9 : 1;
      early = 1'b0;
      drive(op, a, b);
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        if (c == 1) bus.start = 1'b0;
        if (c < lat) begin
          if (bus.acc_write !== 1'b0 || bus.busy !== 1'b1) early = 1'b1;
          bus.a  = 8'($urandom);
          bus.b  = 8'($urandom);
          bus.op = 3'($urandom_range(0, 7));
        end
      end
      total_cnt++; if (early !== 1'b0) $display("FAIL rand[%0d] op=%0d handshake during multiply", n, op); else pass_cnt++;
      total_cnt++;
      if ({bus.acc_write, bus.busy, bus.carry, bus.result, bus.zero} !== {1'b1, 1'b0, exp, (exp[7:0] == 8'h00)})
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: got aw=%b busy=%b c=%b r=%h z=%b want aw=1 busy=0 c=%b r=%h z=%b",
                 n, op, a, b, bus.acc_write, bus.busy, bus.carry, bus.result, bus.zero, exp[8], exp[7:0], (exp[7:0] == 8'h00));
      else pass_cnt++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_mul();
    test_busy_ignore();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
